// File: rtl/branch_redirect_ctrl.sv
// branch_redirect_ctrl
//
// Purpose:
//   Turns a taken branch/jump resolved in EX into a registered PC redirect
//   and a FLUSH_DEPTH-cycle squash of the IF/ID and ID/EX registers. Taken
//   targets that are not 4-byte aligned raise a one-cycle misalign_err pulse
//   instead of redirecting.
//
// Parameters:
//   FLUSH_DEPTH  cycles of flush per taken redirect (1..7)
//   ADDR_W       PC/target width
//
// Ports:
//   clk            core clock, rising edge
//   rst_n          asynchronous active-low reset
//   ex_valid       EX holds a valid instruction
//   ex_is_branch   EX instruction is a branch or jump
//   ex_is_jalr     EX instruction is jalr
//   jump_flag      branch judge says taken
//   ex_target      target computed in EX
//   stall          global stall, freezes this block
//   pc_redirect    load pc_target into the PC
//   pc_target      redirect address
//   flush_ifid     squash IF/ID
//   flush_idex     squash ID/EX
//   busy           flush sequence in progress
//   misalign_err   taken target not 4-byte aligned
//   perf_branch_cnt, perf_taken_cnt  (only with BRANCH_PERF_CNT_EN defined)
//
// Optional feature macro: BRANCH_PERF_CNT_EN adds the two perf counters.

module branch_redirect_ctrl #(
  parameter int unsigned FLUSH_DEPTH = 2,
  parameter int unsigned ADDR_W      = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ex_valid,
  input  logic              ex_is_branch,
  input  logic              ex_is_jalr,
  input  logic              jump_flag,
  input  logic [ADDR_W-1:0] ex_target,
  input  logic              stall,
  output logic              pc_redirect,
  output logic [ADDR_W-1:0] pc_target,
  output logic              flush_ifid,
  output logic              flush_idex,
  output logic              busy,
  output logic              misalign_err
`ifdef BRANCH_PERF_CNT_EN
  ,
  output logic [31:0]       perf_branch_cnt,
  output logic [31:0]       perf_taken_cnt
`endif
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REDIRECT = 2'd1,
    FLUSH    = 2'd2
  } state_t;

  localparam logic [2:0] CNT_LOAD = 3'(FLUSH_DEPTH - 1);

  state_t            state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] target_q, target_d;
  logic              redirect_q, redirect_d;
  logic              flush_q, flush_d;
  logic              busy_q, busy_d;
  logic              misalign_q, misalign_d;

  logic [ADDR_W-1:0] formedTarget;
  logic              accept;

  // jalr clears bit 0 of its target; everything else uses it as computed.
  assign formedTarget = ex_is_jalr ? {ex_target[ADDR_W-1:1], 1'b0} : ex_target;

  // Branches in EX while busy are wrong-path, so only IDLE may accept.
  assign accept = ex_valid & ex_is_branch & jump_flag & ~stall & (state_q == IDLE);

  // Next-state and registered-output logic. Under stall every register
  // keeps its value, which also stretches any pulse currently showing.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    target_d   = target_q;
    redirect_d = redirect_q;
    flush_d    = flush_q;
    busy_d     = busy_q;
    misalign_d = misalign_q;

    if (!stall) begin
      misalign_d = 1'b0;
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            target_d = formedTarget;
            if (formedTarget[1]) begin
              misalign_d = 1'b1;
            end else begin
              state_d = REDIRECT;
              cnt_d   = CNT_LOAD;
            end
          end
        end
        REDIRECT: begin
          state_d = (FLUSH_DEPTH == 1) ? IDLE : FLUSH;
        end
        FLUSH: begin
          cnt_d = cnt_q - 3'd1;
          if (cnt_q <= 3'd1) begin
            state_d = IDLE;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase

      // Outputs are decoded from the upcoming state so they are registered.
      redirect_d = (state_d == REDIRECT);
      flush_d    = (state_d != IDLE);
      busy_d     = (state_d != IDLE);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      target_q   <= '0;
      redirect_q <= 1'b0;
      flush_q    <= 1'b0;
      busy_q     <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      target_q   <= target_d;
      redirect_q <= redirect_d;
      flush_q    <= flush_d;
      busy_q     <= busy_d;
      misalign_q <= misalign_d;
    end
  end

  assign pc_redirect  = redirect_q;
  assign pc_target    = target_q;
  assign flush_ifid   = flush_q;
  assign flush_idex   = flush_q;
  assign busy         = busy_q;
  assign misalign_err = misalign_q;

`ifdef BRANCH_PERF_CNT_EN
  logic [31:0] perfBranch_q, perfTaken_q;

  // Branch counter sees every non-busy unstalled branch; taken counter only
  // aligned accepts. Both wrap naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perfBranch_q <= '0;
      perfTaken_q  <= '0;
    end else begin
      if (!stall && (state_q == IDLE) && ex_valid && ex_is_branch) begin
        perfBranch_q <= perfBranch_q + 32'd1;
      end
      if (accept && !formedTarget[1]) begin
        perfTaken_q <= perfTaken_q + 32'd1;
      end
    end
  end

  assign perf_branch_cnt = perfBranch_q;
  assign perf_taken_cnt  = perfTaken_q;
`endif

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// Self-checking bench for branch_redirect_ctrl: directed scenarios followed
// by randomized traffic, all compared against a cycle-level reference model
// that tracks "flush cycles still owed" as a plain integer.

module tb_branch_redirect_ctrl;

  localparam int FD = 2;
  localparam int AW = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          ex_valid = 1'b0;
  logic          ex_is_branch = 1'b0;
  logic          ex_is_jalr = 1'b0;
  logic          jump_flag = 1'b0;
  logic [AW-1:0] ex_target = '0;
  logic          stall = 1'b0;
  logic          pc_redirect;
  logic [AW-1:0] pc_target;
  logic          flush_ifid;
  logic          flush_idex;
  logic          busy;
  logic          misalign_err;
`ifdef BRANCH_PERF_CNT_EN
  logic [31:0]   perf_branch_cnt;
  logic [31:0]   perf_taken_cnt;
`endif

  int compared = 0;
  int mismatched = 0;

  // Reference model state
  int            seqLeft;
  bit            expRedirect;
  bit            expMis;
  logic [AW-1:0] expTarget;
  bit            stalledPulse;

  // Clock generation
  always #5 clk = ~clk;

  branch_redirect_ctrl #(
    .FLUSH_DEPTH(FD),
    .ADDR_W(AW)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .ex_valid(ex_valid),
    .ex_is_branch(ex_is_branch),
    .ex_is_jalr(ex_is_jalr),
    .jump_flag(jump_flag),
    .ex_target(ex_target),
    .stall(stall),
    .pc_redirect(pc_redirect),
    .pc_target(pc_target),
    .flush_ifid(flush_ifid),
    .flush_idex(flush_idex),
    .busy(busy),
    .misalign_err(misalign_err)
`ifdef BRANCH_PERF_CNT_EN
    ,
    .perf_branch_cnt(perf_branch_cnt),
    .perf_taken_cnt(perf_taken_cnt)
`endif
  );

  // Single comparison point: counts and reports any mismatch
  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, actual, expected, $time);
    end
  endtask

  task automatic modelReset();
    seqLeft     = 0;
    expRedirect = 0;
    expMis      = 0;
    expTarget   = '0;
  endtask

  // One clock edge of the reference behaviour, using inputs held before it
  task automatic modelStep();
    logic [AW-1:0] t;
    bit wasBusy;
    if (stall) return;
    wasBusy     = (seqLeft > 0);
    expMis      = 0;
    expRedirect = 0;
    if (wasBusy) begin
      seqLeft = seqLeft - 1;
    end else if (ex_valid && ex_is_branch && jump_flag) begin
      t = ex_target;
      if (ex_is_jalr) t[0] = 1'b0;
      expTarget = t;
      if (t[1]) begin
        expMis = 1;
      end else begin
        seqLeft     = FD;
        expRedirect = 1;
      end
    end
  endtask

  task automatic checkAll();
    checkOutput("pc_redirect", {63'd0, pc_redirect}, {63'd0, expRedirect});
    checkOutput("pc_target", {{(64-AW){1'b0}}, pc_target}, {{(64-AW){1'b0}}, expTarget});
    checkOutput("flush_ifid", {63'd0, flush_ifid}, {63'd0, (seqLeft > 0)});
    checkOutput("flush_idex", {63'd0, flush_idex}, {63'd0, (seqLeft > 0)});
    checkOutput("busy", {63'd0, busy}, {63'd0, (seqLeft > 0)});
    checkOutput("misalign_err", {63'd0, misalign_err}, {63'd0, expMis});
  endtask

  // Drive one cycle of inputs, clock it, then compare at the falling edge
  task automatic applyStimulus(input bit v, input bit br, input bit jr, input bit jf,
                               input logic [AW-1:0] t, input bit st);
    ex_valid     = v;
    ex_is_branch = br;
    ex_is_jalr   = jr;
    jump_flag    = jf;
    ex_target    = t;
    stall        = st;
    @(posedge clk);
    modelStep();
    @(negedge clk);
    checkAll();
  endtask

  task automatic idleCycle();
    applyStimulus(0, 0, 0, 0, '0, 0);
  endtask

  initial begin
    modelReset();
    $display("[TB] starting, FLUSH_DEPTH=%0d", FD);

    // Reset state
    #12;
    checkAll();
    #1 rst_n = 1'b1;

    // beq taken to 0x100
    applyStimulus(1, 1, 0, 1, 32'h0000_0100, 0);
    checkOutput("tp1_redirect", {63'd0, pc_redirect}, 64'd1);
    checkOutput("tp1_target", {32'd0, pc_target}, 64'h100);
    idleCycle();
    checkOutput("tp1_flush2", {63'd0, flush_ifid}, 64'd1);
    checkOutput("tp1_redirect_done", {63'd0, pc_redirect}, 64'd0);
    idleCycle();
    checkOutput("tp1_busy_low", {63'd0, busy}, 64'd0);

    // jalr to 0x207 -> formed 0x206, misaligned
    applyStimulus(1, 1, 1, 1, 32'h0000_0207, 0);
    checkOutput("tp2_misalign", {63'd0, misalign_err}, 64'd1);
    checkOutput("tp2_no_redirect", {63'd0, pc_redirect}, 64'd0);
    checkOutput("tp2_target", {32'd0, pc_target}, 64'h206);
    idleCycle();
    checkOutput("tp2_mis_pulse", {63'd0, misalign_err}, 64'd0);

    // jalr to 0x201 -> formed 0x200, aligned
    applyStimulus(1, 1, 1, 1, 32'h0000_0201, 0);
    checkOutput("tp2b_redirect", {63'd0, pc_redirect}, 64'd1);
    checkOutput("tp2b_target", {32'd0, pc_target}, 64'h200);
    idleCycle();
    idleCycle();

    // Taken branch, stall 3 cycles during REDIRECT, second branch while busy
    applyStimulus(1, 1, 0, 1, 32'h0000_0400, 0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, 1, 0, 1, 32'h0000_0800, 1);
      checkOutput("tp3_stall_hold", {63'd0, pc_redirect}, 64'd1);
    end
    applyStimulus(1, 1, 0, 1, 32'h0000_0800, 0);
    checkOutput("tp3_resume_flush", {63'd0, flush_idex}, 64'd1);
    checkOutput("tp3_no_extra", {63'd0, pc_redirect}, 64'd0);
    checkOutput("tp3_target_kept", {32'd0, pc_target}, 64'h400);
    idleCycle();

    // bne not taken -> nothing
    applyStimulus(1, 1, 0, 0, 32'h0000_0900, 0);
    checkOutput("tp4_quiet", {63'd0, busy}, 64'd0);
    idleCycle();

    // Reset dropped in FLUSH
    applyStimulus(1, 1, 0, 1, 32'h0000_0a00, 0);
    idleCycle();
    checkOutput("tp5_in_flush", {63'd0, busy}, 64'd1);
    #1 rst_n = 1'b0;
    #1;
    modelReset();
    checkAll();
    #1 rst_n = 1'b1;
    idleCycle();
    idleCycle();

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      logic [AW-1:0] t;
      bit st, v, br, jr, jf;
      st = ($urandom_range(0, 4) == 0);
      v  = ($urandom_range(0, 3) != 0);
      br = ($urandom_range(0, 1) == 1);
      jr = br && ($urandom_range(0, 2) == 0);
      jf = ($urandom_range(0, 1) == 1);
      t  = $urandom;
      if ($urandom_range(0, 3) != 0) t[1] = 1'b0;
      applyStimulus(v, br, jr, jf, t, st);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
